// File: rtl/fv_enc_pkg.sv
// fv_enc_pkg: shared types for the FV encryption sequencer.
//   state_t     - sequencer states
//   coeff_cnt_t - coefficient index for the default ring size
package fv_enc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PASS0,
        ST_DRAIN0,
        ST_PASS1,
        ST_DRAIN1
    } state_t;

    localparam int N_DEF = 16;

    // Modules built for a different N size their counters from their own N.
    typedef logic [$clog2(N_DEF)-1:0] coeff_cnt_t;

endpackage

// File: rtl/fv_coeff_buf.sv
// fv_coeff_buf: N x W register file holding one polynomial.
//   clk          - system clock
//   we/waddr/wdata - single synchronous write port
//   raddr/rdata  - single asynchronous read port
// Contents are not reset; every slot is written during LOAD before use.
module fv_coeff_buf #(
    parameter int N = 16,
    parameter int W = 64
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [$clog2(N)-1:0] waddr,
    input  logic [W-1:0]         wdata,
    input  logic [$clog2(N)-1:0] raddr,
    output logic [W-1:0]         rdata
);

    logic [W-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fv_enc_sched.sv
// fv_enc_sched: sequencer for one FV public-key encryption around an external
// polynomial multiplier.
//   clk, s_rst          - clock, synchronous active-high reset
//   start/busy/done/err - control; err is a sticky framing flag
//   u_*, m_*, e1_*, e2_* - lockstep input streams loaded in LOAD
//   pk_*                - p0 then p1, forwarded to the multiplier in PASS0/1
//   mul_p_*, mul_u_*    - multiplier operand streams
//   mul_z_*             - multiplier result stream (always accepted)
//   ct_*, ct_sel        - ciphertext out: ct0 (sel=0) then ct1 (sel=1)
module fv_enc_sched
    import fv_enc_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int QW          = 64,
    parameter int UW          = 1,
    parameter int DELTA_SHIFT = QW - 1
) (
    input  logic          clk,
    input  logic          s_rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          u_vld,
    output logic          u_rdy,
    input  logic [UW-1:0] u_data,
    input  logic          u_last,
    input  logic          m_vld,
    output logic          m_rdy,
    input  logic          m_data,
    input  logic          m_last,
    input  logic          e1_vld,
    output logic          e1_rdy,
    input  logic [QW-1:0] e1_data,
    input  logic          e1_last,
    input  logic          e2_vld,
    output logic          e2_rdy,
    input  logic [QW-1:0] e2_data,
    input  logic          e2_last,
    input  logic          pk_vld,
    output logic          pk_rdy,
    input  logic [QW-1:0] pk_data,
    input  logic          pk_last,
    output logic          mul_p_vld,
    input  logic          mul_p_rdy,
    output logic [QW-1:0] mul_p_data,
    output logic          mul_p_last,
    output logic          mul_u_vld,
    output logic [UW-1:0] mul_u_data,
    output logic          mul_u_last,
    input  logic          mul_z_vld,
    output logic          mul_z_rdy,
    input  logic [QW-1:0] mul_z_data,
    input  logic          mul_z_last,
    output logic          ct_vld,
    output logic [QW-1:0] ct_data,
    output logic          ct_last,
    output logic          ct_sel
);

    localparam int CW = $clog2(N);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          last_idx, in_pass, in_drain;
    logic          load_fire, pass_fire, z_fire, frame_bad;
    logic [UW-1:0] u_rd;
    logic [0:0]    m_rd;
    logic [QW-1:0] e1_rd, e2_rd, e_rd, m_term, ct_sum;

    assign last_idx  = (cnt == CW'(N - 1));
    assign in_pass   = (state == ST_PASS0) || (state == ST_PASS1);
    assign in_drain  = (state == ST_DRAIN0) || (state == ST_DRAIN1);
    // The four load streams advance together; one beat needs all of them.
    assign load_fire = (state == ST_LOAD) && u_vld && m_vld && e1_vld && e2_vld;
    assign pass_fire = in_pass && pk_vld && mul_p_rdy;
    assign z_fire    = in_drain && mul_z_vld;

    // Sequencing is purely count-based; bad last flags only raise err.
    assign frame_bad = (load_fire && ({u_last, m_last, e1_last, e2_last} != {4{last_idx}}))
                     || (pass_fire && (pk_last != last_idx))
                     || (z_fire && (mul_z_last != last_idx))
                     || (mul_z_vld && !in_drain);

    fv_coeff_buf #(.N(N), .W(UW)) u_buf_i (
        .clk(clk), .we(load_fire), .waddr(cnt), .wdata(u_data), .raddr(cnt), .rdata(u_rd));
    fv_coeff_buf #(.N(N), .W(1)) m_buf_i (
        .clk(clk), .we(load_fire), .waddr(cnt), .wdata(m_data), .raddr(cnt), .rdata(m_rd));
    fv_coeff_buf #(.N(N), .W(QW)) e1_buf_i (
        .clk(clk), .we(load_fire), .waddr(cnt), .wdata(e1_data), .raddr(cnt), .rdata(e1_rd));
    fv_coeff_buf #(.N(N), .W(QW)) e2_buf_i (
        .clk(clk), .we(load_fire), .waddr(cnt), .wdata(e2_data), .raddr(cnt), .rdata(e2_rd));

    always_ff @(posedge clk) begin
        if (s_rst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        busy       = (state != ST_IDLE);
        u_rdy      = (state == ST_LOAD);
        m_rdy      = (state == ST_LOAD);
        e1_rdy     = (state == ST_LOAD);
        e2_rdy     = (state == ST_LOAD);
        pk_rdy     = in_pass && mul_p_rdy;
        mul_p_vld  = in_pass && pk_vld;
        mul_u_vld  = in_pass && pk_vld;
        mul_p_last = in_pass && last_idx;
        mul_u_last = in_pass && last_idx;
        mul_p_data = pk_data;
        mul_u_data = u_rd;
        mul_z_rdy  = 1'b1;
        unique case (state)
            ST_IDLE:   if (start)                  state_nx = ST_LOAD;
            ST_LOAD:   if (load_fire && last_idx)  state_nx = ST_PASS0;
            ST_PASS0:  if (pass_fire && last_idx)  state_nx = ST_DRAIN0;
            ST_DRAIN0: if (z_fire && last_idx)     state_nx = ST_PASS1;
            ST_PASS1:  if (pass_fire && last_idx)  state_nx = ST_DRAIN1;
            ST_DRAIN1: if (z_fire && last_idx)     state_nx = ST_IDLE;
            default:                               state_nx = ST_IDLE;
        endcase
    end

    // N is a power of two, so the index wraps to 0 on its own at N-1,
    // which is exactly the restart every phase change needs.
    always_ff @(posedge clk) begin
        if (s_rst)                              cnt <= '0;
        else if (load_fire || pass_fire || z_fire) cnt <= cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (s_rst)                          err <= 1'b0;
        else if (frame_bad)                 err <= 1'b1;
        else if (state == ST_IDLE && start) err <= 1'b0;
    end

    // Scaled message only contributes to ct0.
    assign m_term = (state == ST_DRAIN0 && m_rd[0]) ? (QW'(1) << DELTA_SHIFT) : '0;
    assign e_rd   = (state == ST_DRAIN1) ? e2_rd : e1_rd;
    assign ct_sum = mul_z_data + e_rd + m_term;

    always_ff @(posedge clk) begin
        if (s_rst) begin
            ct_vld  <= 1'b0;
            ct_data <= '0;
            ct_last <= 1'b0;
            ct_sel  <= 1'b0;
            done    <= 1'b0;
        end else begin
            ct_vld  <= z_fire;
            ct_last <= z_fire && (state == ST_DRAIN1) && last_idx;
            done    <= z_fire && (state == ST_DRAIN1) && last_idx;
            if (z_fire) begin
                ct_data <= ct_sum;
                ct_sel  <= (state == ST_DRAIN1);
            end
        end
    end

endmodule

// File: tb/tb_fv_enc_sched.sv
// tb_fv_enc_sched: scoreboard bench for fv_enc_sched with N=4. A behavioural
// negacyclic multiplier sits on the mul_* ports; expected ct beats are
// computed from the stimulus vectors when a case is launched.
module tb_fv_enc_sched;

    localparam int N  = 4;
    localparam int QW = 64;
    localparam int UW = 1;

    logic          clk, s_rst, start, busy, done, err;
    logic          u_vld, u_rdy, u_last;
    logic [UW-1:0] u_data;
    logic          m_vld, m_rdy, m_data, m_last;
    logic          e1_vld, e1_rdy, e1_last;
    logic [QW-1:0] e1_data;
    logic          e2_vld, e2_rdy, e2_last;
    logic [QW-1:0] e2_data;
    logic          pk_vld, pk_rdy, pk_last;
    logic [QW-1:0] pk_data;
    logic          mul_p_vld, mul_p_rdy, mul_p_last;
    logic [QW-1:0] mul_p_data;
    logic          mul_u_vld, mul_u_last;
    logic [UW-1:0] mul_u_data;
    logic          mul_z_vld, mul_z_rdy, mul_z_last;
    logic [QW-1:0] mul_z_data;
    logic          ct_vld, ct_last, ct_sel;
    logic [QW-1:0] ct_data;

    fv_enc_sched #(.N(N), .QW(QW), .UW(UW), .DELTA_SHIFT(QW-1)) dut (
        .clk(clk), .s_rst(s_rst), .start(start), .busy(busy), .done(done), .err(err),
        .u_vld(u_vld), .u_rdy(u_rdy), .u_data(u_data), .u_last(u_last),
        .m_vld(m_vld), .m_rdy(m_rdy), .m_data(m_data), .m_last(m_last),
        .e1_vld(e1_vld), .e1_rdy(e1_rdy), .e1_data(e1_data), .e1_last(e1_last),
        .e2_vld(e2_vld), .e2_rdy(e2_rdy), .e2_data(e2_data), .e2_last(e2_last),
        .pk_vld(pk_vld), .pk_rdy(pk_rdy), .pk_data(pk_data), .pk_last(pk_last),
        .mul_p_vld(mul_p_vld), .mul_p_rdy(mul_p_rdy), .mul_p_data(mul_p_data),
        .mul_p_last(mul_p_last),
        .mul_u_vld(mul_u_vld), .mul_u_data(mul_u_data), .mul_u_last(mul_u_last),
        .mul_z_vld(mul_z_vld), .mul_z_rdy(mul_z_rdy), .mul_z_data(mul_z_data),
        .mul_z_last(mul_z_last),
        .ct_vld(ct_vld), .ct_data(ct_data), .ct_last(ct_last), .ct_sel(ct_sel));

    typedef struct {
        logic [QW-1:0] d;
        logic          sel;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_bad = 0;
    logic [QW-1:0] p0_v[N], p1_v[N], e1_v[N], e2_v[N];
    logic          u_v[N], m_v[N];
    bit            gap_en = 0;
    bit            abort  = 0;
    int            pk_err_beat = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference negacyclic product coefficient k of (p0|p1) * u.
    function automatic logic [QW-1:0] nc(input bit use_p1, input int k);
        logic [QW-1:0] acc, pv;
        acc = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (u_v[j]) begin
                    pv = use_p1 ? p1_v[i] : p0_v[i];
                    if (i + j == k)          acc = acc + pv;
                    else if (i + j == k + N) acc = acc - pv;
                end
        return acc;
    endfunction

    task automatic push_expected();
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.d    = nc(1'b0, k) + e1_v[k] + (m_v[k] ? 64'h8000_0000_0000_0000 : 64'd0);
            e.sel  = 1'b0;
            e.last = 1'b0;
            sb.push_back(e);
        end
        for (int k = 0; k < N; k++) begin
            e.d    = nc(1'b1, k) + e2_v[k];
            e.sel  = 1'b1;
            e.last = (k == N - 1);
            sb.push_back(e);
        end
    endtask

    // Behavioural multiplier: gathers N operand beats, then emits N results.
    initial begin
        int            cin, cout;
        bit            emit;
        logic [QW-1:0] pc[N], zr[N];
        logic          uc[N];
        cin = 0; cout = 0; emit = 0;
        mul_z_vld = 1'b0; mul_z_data = '0; mul_z_last = 1'b0; mul_p_rdy = 1'b1;
        forever begin
            @(negedge clk);
            mul_z_vld  = 1'b0;
            mul_z_last = 1'b0;
            mul_p_rdy  = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (emit && !(gap_en && $urandom_range(0, 2) == 0)) begin
                mul_z_vld  = 1'b1;
                mul_z_data = zr[cout];
                mul_z_last = (cout == N - 1);
                cout++;
                if (cout == N) begin emit = 0; cout = 0; end
            end
            #2;
            if (s_rst) begin
                cin = 0; cout = 0; emit = 0;
                mul_z_vld = 1'b0; mul_z_last = 1'b0;
            end else if (!emit && mul_p_vld && mul_p_rdy) begin
                chk("mul_last", 64'({mul_p_last, mul_u_last, mul_u_vld}),
                    64'({(cin == N - 1), (cin == N - 1), 1'b1}));
                pc[cin] = mul_p_data;
                uc[cin] = mul_u_data[0];
                cin++;
                if (cin == N) begin
                    for (int k = 0; k < N; k++) zr[k] = '0;
                    for (int j = 0; j < N; j++)
                        if (uc[j])
                            for (int i = 0; i < N; i++)
                                if (i + j < N) zr[i+j]   = zr[i+j] + pc[i];
                                else           zr[i+j-N] = zr[i+j-N] - pc[i];
                    emit = 1;
                    cin  = 0;
                end
            end
        end
    end

    // Output monitor: every ct beat is popped against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ct_vld) begin
                if (sb.size() == 0) chk("ct_extra", 64'(ct_vld), 64'd0);
                else begin
                    e = sb.pop_front();
                    chk("ct_data", ct_data, e.d);
                    chk("ct_sel", 64'(ct_sel), 64'(e.sel));
                    chk("ct_last", 64'(ct_last), 64'(e.last));
                    chk("done", 64'(done), 64'(e.last));
                end
            end else if (done) chk("done_stray", 64'(done), 64'd0);
        end
    end

    task automatic drv_load();
        int idx = 0;
        int cyc = 0;
        while (idx < N && !abort && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (gap_en && $urandom_range(0, 2) == 0) begin
                {u_vld, m_vld, e1_vld, e2_vld} = 4'b0;
            end else begin
                {u_vld, m_vld, e1_vld, e2_vld} = 4'hf;
                u_data  = u_v[idx];
                m_data  = m_v[idx];
                e1_data = e1_v[idx];
                e2_data = e2_v[idx];
                {u_last, m_last, e1_last, e2_last} = {4{idx == N - 1}};
            end
            #1;
            if (u_vld && u_rdy) idx++;
        end
        @(posedge clk);
        #1;
        {u_vld, m_vld, e1_vld, e2_vld} = 4'b0;
        {u_last, m_last, e1_last, e2_last} = 4'b0;
        if (idx < N && !abort) chk("load_timeout", 64'(idx), 64'(N));
    endtask

    task automatic drv_pk();
        int idx = 0;
        int cyc = 0;
        while (idx < 2 * N && !abort && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (gap_en && $urandom_range(0, 2) == 0) pk_vld = 1'b0;
            else begin
                pk_vld  = 1'b1;
                pk_data = (idx < N) ? p0_v[idx] : p1_v[idx-N];
                pk_last = (idx % N == N - 1) || (idx == pk_err_beat);
            end
            #1;
            if (pk_vld && pk_rdy) idx++;
        end
        @(posedge clk);
        #1;
        pk_vld  = 1'b0;
        pk_last = 1'b0;
        if (idx < 2 * N && !abort) chk("pk_timeout", 64'(idx), 64'(2 * N));
    endtask

    task automatic wait_end();
        int cyc = 0;
        while (!(sb.size() == 0 && !busy) && cyc < 600) begin
            @(negedge clk);
            #3;
            cyc++;
        end
        if (cyc >= 600) begin
            chk("end_sb_left", 64'(sb.size()), 64'd0);
            chk("end_busy", 64'(busy), 64'd0);
        end
    endtask

    // Reset as soon as the first ct0 beat appears (multiplier still draining).
    task automatic rst_mid();
        int cyc = 0;
        while (!ct_vld && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        if (!ct_vld) chk("rst_wait", 64'(ct_vld), 64'd1);
        s_rst = 1'b1;
        abort = 1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ct_vld", 64'(ct_vld), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ct_last", 64'(ct_last), 64'd0);
        chk("rst_vlds", 64'({mul_p_vld, mul_u_vld}), 64'd0);
        chk("rst_rdys", 64'({u_rdy, m_rdy, e1_rdy, e2_rdy, pk_rdy}), 64'd0);
        sb.delete();
        s_rst = 1'b0;
    endtask

    task automatic run_case(input bit g, input int errb, input bit exp_err, input bit mid_rst);
        gap_en      = g;
        pk_err_beat = errb;
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start", 64'(busy), 64'd1);
        chk("err_clr", 64'(err), 64'd0);
        fork
            drv_load();
            drv_pk();
            begin
                if (mid_rst) rst_mid();
                else         wait_end();
            end
        join
        if (!mid_rst) begin
            chk("busy_end", 64'(busy), 64'd0);
            chk("err_end", 64'(err), 64'(exp_err));
        end
        abort  = 0;
        gap_en = 0;
    endtask

    task automatic set_case1();
        p0_v = '{64'd1, 64'd2, 64'd3, 64'd4};
        p1_v = '{64'd5, 64'd6, 64'd7, 64'd8};
        u_v  = '{1'b1, 1'b0, 1'b0, 1'b0};
        m_v  = '{default: 1'b0};
        e1_v = '{default: 64'd0};
        e2_v = '{default: 64'd0};
    endtask

    initial begin
        s_rst = 1'b1; start = 1'b0;
        {u_vld, m_vld, e1_vld, e2_vld, pk_vld} = 5'b0;
        {u_last, m_last, e1_last, e2_last, pk_last} = 5'b0;
        u_data = '0; m_data = 1'b0; e1_data = '0; e2_data = '0; pk_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy0", 64'(busy), 64'd0);
        chk("rst_done0", 64'(done), 64'd0);
        chk("rst_err0", 64'(err), 64'd0);
        chk("rst_ct0", 64'({ct_vld, ct_last, ct_sel}), 64'd0);
        chk("rst_ct_data0", ct_data, 64'd0);
        chk("rst_rdy0", 64'({u_rdy, m_rdy, e1_rdy, e2_rdy, pk_rdy}), 64'd0);
        chk("rst_mvld0", 64'({mul_p_vld, mul_u_vld, mul_p_last}), 64'd0);
        s_rst = 1'b0;

        // identity u: ct = p
        set_case1();
        run_case(0, -1, 0, 0);
        // u = x: negacyclic shift with wrap-around negation
        u_v = '{1'b0, 1'b1, 1'b0, 1'b0};
        run_case(0, -1, 0, 0);
        // message and noise
        set_case1();
        m_v  = '{1'b1, 1'b0, 1'b1, 1'b0};
        e1_v = '{default: 64'd1};
        e2_v = '{default: 64'd2};
        run_case(0, -1, 0, 0);
        // stalls on every stream
        set_case1();
        run_case(1, -1, 0, 0);
        // early pk last on p0 beat 2: err but the sequence still completes
        run_case(0, 2, 1, 0);
        // next start clears err
        run_case(0, -1, 0, 0);
        // abandon mid-DRAIN0, then rerun cleanly
        run_case(0, -1, 0, 1);
        run_case(0, -1, 0, 0);
        // random full-width data with stalls
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < N; k++) begin
                p0_v[k] = {$urandom, $urandom};
                p1_v[k] = {$urandom, $urandom};
                e1_v[k] = {$urandom, $urandom};
                e2_v[k] = {$urandom, $urandom};
                u_v[k]  = 1'($urandom_range(0, 1));
                m_v[k]  = 1'($urandom_range(0, 1));
            end
            run_case(1, -1, 0, 0);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fv_enc_sched.md
Name: fv_enc_sched

Overview:
Sequencer for one FV public-key encryption, built around a single polynomial multiplier instance.
- Loads u (R2), message m and errors e1/e2 into local buffers.
- Time-multiplexes the multiplier for two passes: p0*u, then p1*u.
- Adds noise and scaled message to each product stream and emits ct0 = p0*u + e1 + Δm, then ct1 = p1*u + e2.
- All arithmetic is mod 2^QW.

Parameters:
N, 16, coefficients per polynomial (power of 2).
QW, 64, Rq coefficient width (q = 2^QW).
UW, 1, u coefficient width.
DELTA_SHIFT, QW-1, Δ·m realised as m << DELTA_SHIFT (t = 2).

Ports:
clk  in  1  system clock
s_rst  in  1  synchronous reset, active-high
start  in  1  begin encryption; sampled only in IDLE
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse with the final ct beat
err  out  1  sticky framing error; cleared on accepted start
u  axis_if.in  UW  u coeffs, N beats, last on beat N-1
m  axis_if.in  1  message bits, lockstep with u
e1  axis_if.in  QW  error e1, lockstep with u
e2  axis_if.in  QW  error e2, lockstep with u
pk  axis_if.in  QW  p0 (N beats, last) then p1 (N beats, last)
mul_p  axis_if.out  QW  to multiplier p port
mul_u  axis_if.out  UW  to multiplier u port
mul_z  axis_if.in  QW  multiplier result; rdy tied 1
ct  axis_if.out  QW  ct0 then ct1, 2N beats; last on beat 2N-1; rdy not sampled
ct_sel  out  1  0 = ct0 beat, 1 = ct1 beat; valid with ct.vld

Behaviour:
- Reset: state IDLE; cnt=0; busy=0; done=0; err=0; all vld/rdy/last=0; ct.data=0. Buffers are not cleared.
- IDLE:
  - start=1 -> LOAD; err cleared.
  - start while busy is ignored.
- LOAD:
  - u.rdy=m.rdy=e1.rdy=e2.rdy=1 (combinational, all equal).
  - Beat fires only when all four vld=1. Write u_buf/m_buf/e1_buf/e2_buf[cnt], cnt++.
  - On cnt==N-1 fire -> PASS0, cnt=0.
- PASS0/PASS1:
  - mul_p.vld = mul_u.vld = pk.vld; mul_p.data = pk.data; mul_u.data = u_buf[cnt]; pk.rdy = mul_p.rdy.
  - mul_p.last = mul_u.last = (cnt==N-1).
  - Fire = pk.vld && mul_p.rdy.
  - On the N-th fire -> DRAIN0/DRAIN1, cnt=0.
- DRAIN0/DRAIN1:
  - Every mul_z.vld beat i: ct.data <= mul_z.data + eX_buf[i] + (pass0 ? m_buf[i]<<DELTA_SHIFT : 0), truncated to QW.
  - X = 1 in DRAIN0, X = 2 in DRAIN1.
  - ct.vld registered, 1-cycle latency from mul_z.vld; ct_sel registered alongside.
- Transitions:
  - mul_z.last in DRAIN0 -> PASS1.
  - mul_z.last in DRAIN1 -> IDLE; the ct beat carrying ct.last also carries done=1.
- Framing errors (set err, continue the count-based sequence, never hang):
  - any input last on a beat other than N-1;
  - last absent on beat N-1;
  - mul_z.last not on the N-th result;
  - mul_z.vld outside DRAIN.
- Input gaps: vld gaps on any stream stall the counter; no timeout.
- Mid-operation reset: synchronous s_rst returns to IDLE on the next edge; any partial ct stream is abandoned (no last, no done). The multiplier is reset by the same reset.
- Stream gating: all inputs have rdy=0 outside their own state; pk is accepted only in PASS0/PASS1.

Decomposition:
- Package fv_enc_pkg: state_t enum {ST_IDLE, ST_LOAD, ST_PASS0, ST_DRAIN0, ST_PASS1, ST_DRAIN1}; coeff_cnt_t of width $clog2(N).
- Sub-module fv_coeff_buf: parameterised N×W register file, single write port, single async read port.
  - Instantiated four times (u, m, e1, e2).
- The multiplier instance stays outside, wired at fv_enc top.

Test Plan:
N=4, u=[1,0,0,0], p0=[1,2,3,4], p1=[5,6,7,8], m=e=0 -> ct0=[1,2,3,4], ct1=[5,6,7,8], ct_sel 0x4 then 1x4, done with beat 8.
u=[0,1,0,0], p0=[1,2,3,4] -> ct0=[2^64-4,1,2,3] (negacyclic wrap).
Case 1 plus m=[1,0,1,0], e1=[1,1,1,1], e2=[2,2,2,2] -> ct0=[2^63+2,3,2^63+4,5], ct1=[7,8,9,10].
Case 1 with random vld gaps on u/m/e/pk -> identical ct; no beat lost or duplicated.
pk.last on beat 2 of p0 -> err=1, sequence completes, done pulses; next start clears err.
s_rst asserted during DRAIN0 -> next cycle busy=0 and all vld=0; new start runs case 1 correctly.
